// File: rtl/regfile_writeback_queue.sv
// Write-back queue in front of the register file: buffers {reg, data} results,
// drains them in order onto the write port and forwards the newest pending value.
module regfile_writeback_queue #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 2,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_W-1:0]         in_reg,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     wr_stall,
  output logic [REG_W-1:0]         WriteReg,
  output logic [DATA_W-1:0]        WriteData,
  output logic                     RegWrite,
  input  logic [REG_W-1:0]         fwd_reg1,
  output logic                     fwd_hit1,
  output logic [DATA_W-1:0]        fwd_data1,
  input  logic [REG_W-1:0]         fwd_reg2,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_W-1:0]  ent_reg  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  idx;
  logic              push;
  logic              pop;
  logic              nonempty;

  assign nonempty  = (count != '0);
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign RegWrite  = nonempty && !wr_stall;
  assign pop       = RegWrite;
  assign WriteReg  = nonempty ? ent_reg[head]  : '0;
  assign WriteData = nonempty ? ent_data[head] : '0;

  // Control state: pointers, occupancy and per-entry valid bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (push) begin
        tail          <= tail + 1'b1;
        ent_vld[tail] <= 1'b1;
      end
      if (pop) begin
        head          <= head + 1'b1;
        ent_vld[head] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage; validity is tracked by ent_vld, so no reset needed here
  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg[tail]  <= in_reg;
      ent_data[tail] <= in_data;
    end
  end

  // Scan oldest to youngest so the last match wins (newest pending value)
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (ent_vld[idx] && (ent_reg[idx] == fwd_reg1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = ent_data[idx];
      end
      if (ent_vld[idx] && (ent_reg[idx] == fwd_reg2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = ent_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed vector table, hand-written corner
// sequences, and a queue-based reference model checked on every falling edge.
module tb_regfile_writeback_queue;
  localparam int DATA_W = 32;
  localparam int REG_W  = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [REG_W-1:0]  in_reg = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              wr_stall = 1'b0;
  logic [REG_W-1:0]  WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic [REG_W-1:0]  fwd_reg1 = '0;
  logic              fwd_hit1;
  logic [DATA_W-1:0] fwd_data1;
  logic [REG_W-1:0]  fwd_reg2 = '0;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data2;
  logic [2:0]        count;

  always #5 clk = ~clk;

  regfile_writeback_queue #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .wr_stall(wr_stall),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .fwd_reg1(fwd_reg1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_reg2(fwd_reg2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected writes queued on acceptance, retired on issue
  typedef struct {
    logic [REG_W-1:0]  r;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t mq[$];

  always @(posedge clk or negedge reset) begin : model_upd
    bit p_push, p_pop;
    if (!reset) begin
      mq.delete();
    end else begin
      p_pop  = (mq.size() != 0) && !wr_stall;
      p_push = in_valid && (mq.size() != DEPTH);
      if (p_pop) void'(mq.pop_front());
      if (p_push) mq.push_back('{in_reg, in_data});
    end
  end

  always @(negedge clk) begin : model_chk
    logic              e_rw, e_h1, e_h2;
    logic [REG_W-1:0]  e_wr;
    logic [DATA_W-1:0] e_wd, e_d1, e_d2;
    e_rw = (mq.size() != 0) && !wr_stall;
    e_wr = (mq.size() != 0) ? mq[0].r : '0;
    e_wd = (mq.size() != 0) ? mq[0].d : '0;
    e_h1 = 1'b0; e_d1 = '0; e_h2 = 1'b0; e_d2 = '0;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].r == fwd_reg1) begin e_h1 = 1'b1; e_d1 = mq[i].d; end
      if (mq[i].r == fwd_reg2) begin e_h2 = 1'b1; e_d2 = mq[i].d; end
    end
    chk("model_regwrite", RegWrite, e_rw);
    chk("model_writereg", WriteReg, e_wr);
    chk("model_writedata", WriteData, e_wd);
    chk("model_count", count, mq.size());
    chk("model_in_ready", in_ready, mq.size() != DEPTH);
    chk("model_hit1", fwd_hit1, e_h1);
    chk("model_data1", fwd_data1, e_d1);
    chk("model_hit2", fwd_hit2, e_h2);
    chk("model_data2", fwd_data2, e_d2);
  end

  typedef struct {
    logic v; logic [1:0] r; logic [31:0] d; logic s; logic [1:0] f1; logic [1:0] f2;
    logic rw; logic [1:0] wr; logic [31:0] wd; logic [2:0] cnt; logic rdy;
    logic h1; logic [31:0] d1; logic h2; logic [31:0] d2;
  } vec_t;
  vec_t vecs[20];

  task automatic drive(input logic v, input logic [1:0] r, input logic [31:0] d,
                       input logic s, input logic [1:0] f1, input logic [1:0] f2);
    in_valid = v; in_reg = r; in_data = d; wr_stall = s; fwd_reg1 = f1; fwd_reg2 = f2;
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // v r d s f1 f2 | rw wr wd cnt rdy h1 d1 h2 d2
    vecs[0]  = '{1, 2, 32'hDEADBEEF, 0, 2, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 2, 0,  1, 2, 32'hDEADBEEF, 1, 1, 1, 32'hDEADBEEF, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 2, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 1, 1, 0, 3,  0, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[4]  = '{1, 1, 2, 1, 0, 3,  0, 0, 1, 1, 1, 1, 1, 0, 0};
    vecs[5]  = '{1, 2, 3, 1, 0, 3,  0, 0, 1, 2, 1, 1, 1, 0, 0};
    vecs[6]  = '{1, 3, 4, 1, 0, 3,  0, 0, 1, 3, 1, 1, 1, 0, 0};
    vecs[7]  = '{1, 0, 5, 1, 0, 3,  0, 0, 1, 4, 0, 1, 1, 1, 4};
    vecs[8]  = '{0, 0, 0, 0, 0, 3,  1, 0, 1, 4, 0, 1, 1, 1, 4};
    vecs[9]  = '{0, 0, 0, 0, 0, 3,  1, 1, 2, 3, 1, 0, 0, 1, 4};
    vecs[10] = '{0, 0, 0, 0, 0, 3,  1, 2, 3, 2, 1, 0, 0, 1, 4};
    vecs[11] = '{0, 0, 0, 0, 0, 3,  1, 3, 4, 1, 1, 0, 0, 1, 4};
    vecs[12] = '{0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[13] = '{1, 1, 32'hAA, 1, 1, 3,  0, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[14] = '{1, 1, 32'hBB, 1, 1, 3,  0, 1, 32'hAA, 1, 1, 1, 32'hAA, 0, 0};
    vecs[15] = '{0, 0, 0, 1, 1, 3,  0, 1, 32'hAA, 2, 1, 1, 32'hBB, 0, 0};
    vecs[16] = '{0, 0, 0, 0, 1, 3,  1, 1, 32'hAA, 2, 1, 1, 32'hBB, 0, 0};
    vecs[17] = '{0, 0, 0, 1, 1, 3,  0, 1, 32'hBB, 1, 1, 1, 32'hBB, 0, 0};
    vecs[18] = '{0, 0, 0, 0, 1, 3,  1, 1, 32'hBB, 1, 1, 1, 32'hBB, 0, 0};
    vecs[19] = '{0, 0, 0, 0, 1, 3,  0, 0, 0, 0, 1, 0, 0, 0, 0};

    // Reset state
    @(negedge clk);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_writereg", WriteReg, 0);
    chk("rst_writedata", WriteData, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_hit1", fwd_hit1, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].s, vecs[i].f1, vecs[i].f2);
      @(negedge clk);
      chk($sformatf("vec%0d_regwrite", i), RegWrite, vecs[i].rw);
      chk($sformatf("vec%0d_writereg", i), WriteReg, vecs[i].wr);
      chk($sformatf("vec%0d_writedata", i), WriteData, vecs[i].wd);
      chk($sformatf("vec%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].rdy);
      chk($sformatf("vec%0d_hit1", i), fwd_hit1, vecs[i].h1);
      chk($sformatf("vec%0d_data1", i), fwd_data1, vecs[i].d1);
      chk($sformatf("vec%0d_hit2", i), fwd_hit2, vecs[i].h2);
      chk($sformatf("vec%0d_data2", i), fwd_data2, vecs[i].d2);
      @(posedge clk);
      #1;
    end

    // Steady push+pop at count=2 across pointer wrap
    drive(1, 0, 32'h10, 1, 0, 0); step();
    drive(1, 1, 32'h11, 1, 0, 0); step();
    for (int k = 0; k < 6; k++) begin
      drive(1, 2'((k + 2) % 4), 32'h20 + k, 0, 2'(k % 4), 2'((k + 1) % 4));
      @(negedge clk);
      chk($sformatf("pp%0d_count", k), count, 2);
      chk($sformatf("pp%0d_regwrite", k), RegWrite, 1);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Reset while draining three entries
    for (int k = 0; k < 4; k++) begin
      drive(1, 2'(k), 32'h60 + k, 1, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    #2 reset = 1'b0;
    #1;
    chk("midrst_regwrite", RegWrite, 0);
    chk("midrst_count", count, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d_regwrite", k), RegWrite, 0);
    end
    @(posedge clk);
    #1 drive(1, 2, 32'h77, 0, 2, 0);
    step();
    drive(0, 0, 0, 0, 2, 0);
    @(negedge clk);
    chk("postrst_newwrite", RegWrite, 1);
    chk("postrst_newdata", WriteData, 32'h77);
    @(posedge clk);
    #1;

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) step();
    chk("final_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
